// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage:
//   - datapath / register-address default widths
//   - movOp byte-lane encodings
//   - memory-access FSM state type
package mem_pkg;

  localparam int DW_DEF = 16;
  localparam int RW_DEF = 4;

  // movOp encodings; any other value behaves as a full word.
  localparam logic [3:0] MOV_WORD = 4'd0;
  localparam logic [3:0] MOV_BZX  = 4'd1;
  localparam logic [3:0] MOV_BSX  = 4'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational byte-lane handling for the memory stage.
//   movop_i   : movOp selecting word / byte zero-extend / byte sign-extend
//   st_data_i : raw store data
//   ld_data_i : raw load data
//   be_o      : byte enables {hi,lo}
//   wdata_o   : store data placed on the bus
//   ld_o      : extended load data for write-back
module mem_lane_fmt
  import mem_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [3:0]    movop_i,
  input  logic [DW-1:0] st_data_i,
  input  logic [DW-1:0] ld_data_i,
  output logic [1:0]    be_o,
  output logic [DW-1:0] wdata_o,
  output logic [DW-1:0] ld_o
);

  logic is_byte;

  assign is_byte = (movop_i == MOV_BZX) || (movop_i == MOV_BSX);

  always_comb begin
    be_o    = 2'b11;
    wdata_o = st_data_i;
    if (is_byte) begin
      // Byte stores always use the low lane.
      be_o    = 2'b01;
      wdata_o = {{(DW-8){1'b0}}, st_data_i[7:0]};
    end
  end

  always_comb begin
    ld_o = ld_data_i;
    if (movop_i == MOV_BZX) begin
      ld_o = {{(DW-8){1'b0}}, ld_data_i[7:0]};
    end else if (movop_i == MOV_BSX) begin
      ld_o = {{(DW-8){ld_data_i[7]}}, ld_data_i[7:0]};
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage plus MEM/WB pipeline register.
//   Inputs from EX/M buffer : MemtoReg_in, MemWrite_in, MemRead_in, R15_in,
//                             RegWrite_in, ALU_Result_in, ALU_Remainder_in,
//                             store_data_in, movOp_in, EXM_RegRD_in
//   Memory port             : mem_req/mem_we/mem_be/mem_addr/mem_wdata out,
//                             mem_ack/mem_rdata in
//   Pipeline control        : stall_out (freeze IF..EX/M), mem_err (sticky)
//   Forwarding              : fwd_valid, fwd_rd, fwd_data
//   MEM/WB register         : RegWrite_wb, R15_wb, MemtoReg_wb, wb_data,
//                             wb_r15_data, MWB_RegRD_out
//   Debug                   : dbg_state (current FSM state)
//
// Memory handshake: mem_req is raised with a stable address/data/we/be and
// held until the cycle mem_ack is seen in ACCESS; mem_rdata is taken in that
// same cycle. An ack in the request cycle (IDLE) is ignored.
module mem_wb_stage
  import mem_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int RW          = RW_DEF,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          MemtoReg_in,
  input  logic          MemWrite_in,
  input  logic          MemRead_in,
  input  logic          R15_in,
  input  logic          RegWrite_in,
  input  logic [DW-1:0] ALU_Result_in,
  input  logic [DW-1:0] ALU_Remainder_in,
  input  logic [DW-1:0] store_data_in,
  input  logic [3:0]    movOp_in,
  input  logic [RW-1:0] EXM_RegRD_in,
  output logic          mem_req,
  output logic          mem_we,
  output logic [1:0]    mem_be,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_out,
  output logic          mem_err,
  output logic          fwd_valid,
  output logic [RW-1:0] fwd_rd,
  output logic [DW-1:0] fwd_data,
  output logic          RegWrite_wb,
  output logic          R15_wb,
  output logic          MemtoReg_wb,
  output logic [DW-1:0] wb_data,
  output logic [DW-1:0] wb_r15_data,
  output logic [RW-1:0] MWB_RegRD_out,
  output logic [1:0]    dbg_state
);

  state_e        state_q;
  logic [7:0]    cnt_q;
  logic [DW-1:0] rdata_q;

  // Held memory operation, captured in IDLE when the request is issued.
  logic          h_we_q, h_memtoreg_q, h_regwrite_q, h_r15_q;
  logic [3:0]    h_mov_q;
  logic [DW-1:0] h_addr_q, h_wdata_q, h_rem_q;
  logic [RW-1:0] h_rd_q;

  logic          mem_op_in;
  logic          drive_bus;
  logic [3:0]    fmt_mov;
  logic [DW-1:0] fmt_st;
  logic [1:0]    fmt_be;
  logic [DW-1:0] fmt_wdata;
  logic [DW-1:0] fmt_ld;

  assign mem_op_in = MemRead_in | MemWrite_in;
  assign dbg_state = state_q;

  mem_lane_fmt #(.DW(DW)) u_fmt (
    .movop_i   (fmt_mov),
    .st_data_i (fmt_st),
    .ld_data_i (rdata_q),
    .be_o      (fmt_be),
    .wdata_o   (fmt_wdata),
    .ld_o      (fmt_ld)
  );

  // Memory bus and stall. In the request cycle the bus is driven straight
  // from the inputs; afterwards from the held copy, so upstream may change.
  always_comb begin
    mem_req   = 1'b0;
    stall_out = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    drive_bus = 1'b0;
    fmt_mov   = h_mov_q;
    fmt_st    = h_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_op_in && rst_n) begin
          mem_req   = 1'b1;
          stall_out = 1'b1;
          mem_we    = MemWrite_in;
          mem_addr  = ALU_Result_in;
          fmt_mov   = movOp_in;
          fmt_st    = store_data_in;
          drive_bus = 1'b1;
        end
      end
      ST_ACCESS: begin
        mem_req   = 1'b1;
        stall_out = 1'b1;
        mem_we    = h_we_q;
        mem_addr  = h_addr_q;
        drive_bus = 1'b1;
      end
      ST_DONE: begin
        // A new memory op cannot start until IDLE, so keep upstream frozen.
        stall_out = mem_op_in;
      end
      default: ;
    endcase
    mem_be    = drive_bus ? fmt_be : 2'b00;
    mem_wdata = drive_bus ? fmt_wdata : '0;
  end

  assign fwd_valid = rst_n & RegWrite_in & ~MemRead_in & (EXM_RegRD_in != '0);
  assign fwd_rd    = rst_n ? EXM_RegRD_in : '0;
  assign fwd_data  = rst_n ? ALU_Result_in : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      rdata_q       <= '0;
      mem_err       <= 1'b0;
      h_we_q        <= 1'b0;
      h_memtoreg_q  <= 1'b0;
      h_regwrite_q  <= 1'b0;
      h_r15_q       <= 1'b0;
      h_mov_q       <= '0;
      h_addr_q      <= '0;
      h_wdata_q     <= '0;
      h_rem_q       <= '0;
      h_rd_q        <= '0;
      RegWrite_wb   <= 1'b0;
      R15_wb        <= 1'b0;
      MemtoReg_wb   <= 1'b0;
      wb_data       <= '0;
      wb_r15_data   <= '0;
      MWB_RegRD_out <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mem_op_in) begin
            h_we_q       <= MemWrite_in;  // read+write resolves to store
            h_memtoreg_q <= MemtoReg_in;
            h_regwrite_q <= RegWrite_in;
            h_r15_q      <= R15_in;
            h_mov_q      <= movOp_in;
            h_addr_q     <= ALU_Result_in;
            h_wdata_q    <= store_data_in;
            h_rem_q      <= ALU_Remainder_in;
            h_rd_q       <= EXM_RegRD_in;
            cnt_q        <= '0;
            RegWrite_wb  <= 1'b0;
            R15_wb       <= 1'b0;
            state_q      <= ST_ACCESS;
          end else begin
            RegWrite_wb   <= RegWrite_in;
            R15_wb        <= R15_in;
            MemtoReg_wb   <= MemtoReg_in;
            wb_data       <= ALU_Result_in;
            wb_r15_data   <= ALU_Remainder_in;
            MWB_RegRD_out <= EXM_RegRD_in;
          end
        end
        ST_ACCESS: begin
          RegWrite_wb <= 1'b0;
          R15_wb      <= 1'b0;
          if (mem_ack) begin
            rdata_q <= mem_rdata;
            state_q <= ST_DONE;
          end else if (cnt_q == 8'(ACK_TIMEOUT - 1)) begin
            // Last allowed ACCESS cycle passed without ack: abort with zero data.
            mem_err <= 1'b1;
            rdata_q <= '0;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_DONE: begin
          RegWrite_wb   <= h_regwrite_q & ~h_we_q;
          R15_wb        <= h_r15_q;
          MemtoReg_wb   <= h_memtoreg_q;
          wb_data       <= h_memtoreg_q ? fmt_ld : h_addr_q;
          wb_r15_data   <= h_rem_q;
          MWB_RegRD_out <= h_rd_q;
          state_q       <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory stage plus MEM/WB pipeline register; sits directly downstream of the EX/M buffer and consumes its registered outputs.
- Performs data-memory load/store through a req/ack handshake, applies movOp byte-lane handling, stalls the upstream pipeline while memory is busy, and registers the write-back bundle (result, remainder/R15, RD, RegWrite).
- Exposes MEM-stage forwarding data to the forwarding unit.

Parameters:
- DW, 16, datapath width
- RW, 4, register-address width
- ACK_TIMEOUT, 15, max cycles to wait for mem_ack before abort (1..255)

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- MemtoReg_in, MemWrite_in, MemRead_in, R15_in, RegWrite_in  in  1 each  control from EX/M buffer
- ALU_Result_in  in  DW  address for memory ops, else result
- ALU_Remainder_in  in  DW  remainder destined for R15
- store_data_in  in  DW  store data (forwarded RT value)
- movOp_in  in  4  0=word, 1=byte zero-extend, 2=byte sign-extend, other=word
- EXM_RegRD_in  in  RW  destination register
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1=store
- mem_be  out  2  byte enables {hi,lo}
- mem_addr  out  DW  memory address
- mem_wdata  out  DW  store data
- mem_ack  in  1  memory completion
- mem_rdata  in  DW  load data, valid with mem_ack
- stall_out  out  1  freeze IF..EX/M
- mem_err  out  1  sticky timeout flag
- fwd_valid  out  1  MEM-stage result forwardable (RegWrite, not load)
- fwd_rd  out  RW ; fwd_data  out  DW  MEM forwarding bus
- RegWrite_wb, R15_wb, MemtoReg_wb  out  1 each  registered WB controls
- wb_data  out  DW  final write-back value
- wb_r15_data  out  DW  registered remainder
- MWB_RegRD_out  out  RW  registered destination

Behaviour:
- Reset (rst_n low, async): FSM=IDLE; all outputs 0; mem_err cleared; timeout counter 0.
- FSM states IDLE, ACCESS, DONE.
- IDLE: if MemRead_in|MemWrite_in -> capture address/data/controls into holding regs, assert mem_req and stall_out combinationally this cycle, go ACCESS. Otherwise non-memory op passes through: MEM/WB regs load inputs next edge (latency 1).
- ACCESS: mem_req=1, stall_out=1, counter increments each cycle. On mem_ack -> latch mem_rdata, go DONE. If counter reaches ACK_TIMEOUT with no ack -> set mem_err, load data = 0, go DONE.
- DONE: stall_out=0; MEM/WB regs load held op (RegWrite_wb from held RegWrite_in, wb_data = formatted load data when MemtoReg else held ALU result); return IDLE. A new memory op presented in DONE is not accepted until IDLE (upstream still frozen that cycle via stall_out=1 on DONE if MemRead_in|MemWrite_in).
- While stalled, MEM/WB registers insert a bubble (RegWrite_wb=0, R15_wb=0) every cycle before DONE.
- ack in same cycle as request (IDLE) is ignored; ack only sampled in ACCESS. Read-and-write both set: treated as store.
- Store: mem_we=1. movOp 1/2: mem_be=2'b01, mem_wdata={8'h00, data[7:0]}; else mem_be=2'b11.
- Load formatting: movOp 1 -> {8'h00, rdata[7:0]}; 2 -> {{8{rdata[7]}}, rdata[7:0]}; else rdata.
- Stores never write back (RegWrite_wb forced 0).
- Forwarding: fwd_valid = RegWrite_in & ~MemRead_in & (EXM_RegRD_in != 0); fwd_data = ALU_Result_in.
- mem_err cleared only by reset.
- Reset mid-ACCESS: drop mem_req immediately; no write-back.

Decomposition:
- Package mem_pkg: movOp encodings (MOV_WORD, MOV_BZX, MOV_BSX), FSM state typedef, DW/RW defaults.
- Sub-module mem_lane_fmt: combinational store byte-lane/enable generation and load extension.

Test Plan:
- Non-memory op ALU_Result=16'h1234, RD=3, RegWrite=1 -> next edge wb_data=16'h1234, MWB_RegRD_out=3, stall_out never 1.
- Load word addr 16'h0040, ack after 3 cycles with rdata 16'hBEEF -> stall_out high 4 cycles, then wb_data=16'hBEEF, RegWrite_wb=1.
- Load movOp=2, rdata=16'h1280 -> wb_data=16'hFF80; movOp=1 -> 16'h0080.
- Store movOp=1, data 16'hABCD -> mem_we=1, mem_be=2'b01, mem_wdata=16'h00CD, RegWrite_wb=0.
- No ack, ACK_TIMEOUT=15 -> after 15 ACCESS cycles mem_err=1, wb_data=0, FSM back to IDLE.
- rst_n low during ACCESS -> mem_req, stall_out, RegWrite_wb drop to 0 asynchronously; mem_err=0.
